// File: rtl/pim_input_buffer.sv
// pim_input_buffer: ping-pong buffer assembling 32x32b bus words into 1024b PIM input vectors.
module pim_input_buffer (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clear_i,
  input  logic          store_en_i,
  input  logic [4:0]    store_cnt_i,
  input  logic [31:0]   store_data_i,
  output logic          store_ready_o,
  output logic          pim_in_valid_o,
  input  logic          pim_in_ack_i,
  output logic [1023:0] pim_input_o,
  output logic          seq_err_o,
  output logic          ovf_err_o
);
  logic [1023:0] r_bank [2];
  logic          r_wr_ptr, r_rd_ptr, r_seq_err, r_ovf_err;
  logic [1:0]    r_full_cnt;
  logic [4:0]    r_exp_cnt;
  logic          w_accept, w_commit, w_ack, w_seq, w_ovf;

  assign store_ready_o  = r_full_cnt != 2'd2;
  assign pim_in_valid_o = r_full_cnt != 2'd0;
  assign pim_input_o    = pim_in_valid_o ? r_bank[r_rd_ptr] : '0;
  assign seq_err_o      = r_seq_err;
  assign ovf_err_o      = r_ovf_err;
  assign w_accept = store_en_i && store_ready_o && store_cnt_i == r_exp_cnt;
  assign w_commit = w_accept && store_cnt_i == 5'd0;
  assign w_ack    = pim_in_ack_i && pim_in_valid_o;
  assign w_seq    = store_en_i && store_ready_o && store_cnt_i != r_exp_cnt;
  assign w_ovf    = store_en_i && !store_ready_o;

  // index k lands in group 31-k, i.e. bits [32k+31:32k]
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      r_bank[0] <= '0;
      r_bank[1] <= '0;
    end else if (!clear_i && w_accept)
      r_bank[r_wr_ptr][{store_cnt_i, 5'd0} +: 32] <= store_data_i;

  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      r_wr_ptr   <= 1'b0;
      r_rd_ptr   <= 1'b0;
      r_full_cnt <= 2'd0;
      r_exp_cnt  <= 5'd31;
      r_seq_err  <= 1'b0;
      r_ovf_err  <= 1'b0;
    end else if (clear_i) begin
      r_wr_ptr   <= 1'b0;
      r_rd_ptr   <= 1'b0;
      r_full_cnt <= 2'd0;
      r_exp_cnt  <= 5'd31;
      r_seq_err  <= 1'b0;
      r_ovf_err  <= 1'b0;
    end else begin
      if (w_accept)
        r_exp_cnt <= w_commit ? 5'd31 : r_exp_cnt - 5'd1;
      else if (w_seq)
        r_exp_cnt <= 5'd31;
      if (w_commit)
        r_wr_ptr <= ~r_wr_ptr;
      if (w_ack)
        r_rd_ptr <= ~r_rd_ptr;
      r_full_cnt <= r_full_cnt + {1'b0, w_commit} - {1'b0, w_ack};
      if (w_seq)
        r_seq_err <= 1'b1;
      if (w_ovf)
        r_ovf_err <= 1'b1;
    end
endmodule

// File: tb/tb_pim_input_buffer.sv
// tb_pim_input_buffer: table-driven, directed and randomized checks against a queue-based vector model.
module tb_pim_input_buffer;
  logic          clk_i, rst_ni, clear_i, store_en_i, pim_in_ack_i;
  logic [4:0]    store_cnt_i;
  logic [31:0]   store_data_i;
  logic          store_ready_o, pim_in_valid_o, seq_err_o, ovf_err_o;
  logic [1023:0] pim_input_o;

  pim_input_buffer dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i), .store_en_i(store_en_i),
    .store_cnt_i(store_cnt_i), .store_data_i(store_data_i), .store_ready_o(store_ready_o),
    .pim_in_valid_o(pim_in_valid_o), .pim_in_ack_i(pim_in_ack_i), .pim_input_o(pim_input_o),
    .seq_err_o(seq_err_o), .ovf_err_o(ovf_err_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int pass_cnt = 0, tot_cnt = 0;

  // model: completed vectors waiting for the PIM, words of the vector in progress
  logic [1023:0] mq [$];
  logic [31:0]   part [32];
  int            m_exp = 31;
  bit            m_seq = 0, m_ovf = 0;

  typedef struct {
    int          op;
    logic [31:0] base;
    logic        r, v, s, o;
    logic [31:0] g0, g31;
  } rec_t;
  localparam int OP_FILL = 0, OP_ACK = 1, OP_ST31 = 2, OP_CLR = 3;
  rec_t tbl [8];

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    tot_cnt++;
    if (a === e) pass_cnt++;
    else $display("FAIL %s act=%h exp=%h", nm, a, e);
  endtask

  task automatic chk_vec(input string nm, input logic [1023:0] a, input logic [1023:0] e);
    tot_cnt++;
    if (a === e) pass_cnt++;
    else begin
      int g = 0;
      for (int i = 31; i >= 0; i--)
        if (a[1023-32*i -: 32] !== e[1023-32*i -: 32]) g = i;
      $display("FAIL %s group %0d act=%h exp=%h", nm, g, a[1023-32*g -: 32], e[1023-32*g -: 32]);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_exp = 31;
    m_seq = 0;
    m_ovf = 0;
  endtask

  task automatic check_model();
    logic [1023:0] ev;
    ev = (mq.size() != 0) ? mq[0] : '0;
    chk("ready", {31'd0, store_ready_o}, {31'd0, mq.size() != 2});
    chk("valid", {31'd0, pim_in_valid_o}, {31'd0, mq.size() != 0});
    chk("seq_err", {31'd0, seq_err_o}, {31'd0, m_seq});
    chk("ovf_err", {31'd0, ovf_err_o}, {31'd0, m_ovf});
    chk_vec("pim_input", pim_input_o, ev);
  endtask

  task automatic cyc(input bit en, input int cnt, input logic [31:0] d, input bit ack, input bit clr);
    bit rdy, vld;
    logic [1023:0] v;
    rdy = mq.size() != 2;
    vld = mq.size() != 0;
    store_en_i = en; store_cnt_i = cnt[4:0]; store_data_i = d;
    pim_in_ack_i = ack; clear_i = clr;
    @(posedge clk_i);
    if (clr) begin
      mq.delete(); m_exp = 31; m_seq = 0; m_ovf = 0;
    end else begin
      if (ack && vld) void'(mq.pop_front());
      if (en && !rdy) m_ovf = 1;
      else if (en && cnt != m_exp) begin
        m_seq = 1; m_exp = 31;
      end else if (en) begin
        part[31-cnt] = d;
        if (cnt == 0) begin
          for (int g = 0; g < 32; g++) v[1023-32*g -: 32] = part[g];
          mq.push_back(v);
          m_exp = 31;
        end else m_exp--;
      end
    end
    #1;
    store_en_i = 0; store_cnt_i = '0; store_data_i = '0; pim_in_ack_i = 0; clear_i = 0;
    check_model();
  endtask

  task automatic fill(input logic [31:0] base, input int last);
    for (int k = 31; k >= last; k--) cyc(1, k, base + 32'(31 - k), 0, 0);
  endtask

  initial begin
    tbl[0] = '{OP_FILL, 32'h1000_0000, 1, 1, 0, 0, 32'h1000_0000, 32'h1000_001F};
    tbl[1] = '{OP_ACK,  32'h0,         1, 0, 0, 0, 32'h0,         32'h0};
    tbl[2] = '{OP_FILL, 32'hAAAA_0000, 1, 1, 0, 0, 32'hAAAA_0000, 32'hAAAA_001F};
    tbl[3] = '{OP_FILL, 32'hBBBB_0000, 0, 1, 0, 0, 32'hAAAA_0000, 32'hAAAA_001F};
    tbl[4] = '{OP_ST31, 32'hDEAD_BEEF, 0, 1, 0, 1, 32'hAAAA_0000, 32'hAAAA_001F};
    tbl[5] = '{OP_ACK,  32'h0,         1, 1, 0, 1, 32'hBBBB_0000, 32'hBBBB_001F};
    tbl[6] = '{OP_ACK,  32'h0,         1, 0, 0, 1, 32'h0,         32'h0};
    tbl[7] = '{OP_CLR,  32'h0,         1, 0, 0, 0, 32'h0,         32'h0};
    rst_ni = 0; clear_i = 0; store_en_i = 0; store_cnt_i = '0; store_data_i = '0; pim_in_ack_i = 0;
    model_reset();
    repeat (2) @(posedge clk_i);
    #3 rst_ni = 1;
    @(posedge clk_i); #1;
    check_model();
    chk("rst_ready", {31'd0, store_ready_o}, 32'd1);
    chk_vec("rst_input", pim_input_o, '0);

    for (int i = 0; i < 8; i++) begin
      case (tbl[i].op)
        OP_FILL: fill(tbl[i].base, 0);
        OP_ACK:  cyc(0, 0, 0, 1, 0);
        OP_ST31: cyc(1, 31, tbl[i].base, 0, 0);
        default: cyc(0, 0, 0, 0, 1);
      endcase
      chk($sformatf("tbl%0d_ready", i), {31'd0, store_ready_o}, {31'd0, tbl[i].r});
      chk($sformatf("tbl%0d_valid", i), {31'd0, pim_in_valid_o}, {31'd0, tbl[i].v});
      chk($sformatf("tbl%0d_seq", i), {31'd0, seq_err_o}, {31'd0, tbl[i].s});
      chk($sformatf("tbl%0d_ovf", i), {31'd0, ovf_err_o}, {31'd0, tbl[i].o});
      chk($sformatf("tbl%0d_g0", i), pim_input_o[1023:992], tbl[i].g0);
      chk($sformatf("tbl%0d_g31", i), pim_input_o[31:0], tbl[i].g31);
    end

    // commit of B coinciding with ack of A
    fill(32'hAAAA_0000, 0);
    fill(32'hBBBB_0000, 1);
    cyc(1, 0, 32'hBBBB_001F, 1, 0);
    chk("cack_valid", {31'd0, pim_in_valid_o}, 32'd1);
    chk("cack_ready", {31'd0, store_ready_o}, 32'd1);
    chk("cack_g0", pim_input_o[1023:992], 32'hBBBB_0000);
    cyc(0, 0, 0, 1, 0);
    chk("cack_drain", {31'd0, pim_in_valid_o}, 32'd0);

    // out-of-order index, then clean restart
    cyc(1, 31, 32'hC000_0000, 0, 0);
    cyc(1, 30, 32'hC000_0001, 0, 0);
    cyc(1, 28, 32'hC000_0003, 0, 0);
    chk("seq_flag", {31'd0, seq_err_o}, 32'd1);
    chk("seq_novalid", {31'd0, pim_in_valid_o}, 32'd0);
    fill(32'hD000_0000, 0);
    chk("seq_restart_valid", {31'd0, pim_in_valid_o}, 32'd1);
    chk("seq_restart_g2", pim_input_o[959:928], 32'hD000_0002);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 1);

    // flush mid-fill
    fill(32'hE000_0000, 22);
    cyc(0, 0, 0, 0, 1);
    chk("clr_valid", {31'd0, pim_in_valid_o}, 32'd0);
    cyc(1, 21, 32'hE000_000A, 0, 0);
    chk("clr_need31", {31'd0, seq_err_o}, 32'd1);
    cyc(0, 0, 0, 0, 1);
    fill(32'hF000_0000, 0);
    chk("clr_refill_g31", pim_input_o[31:0], 32'hF000_001F);

    // asynchronous reset during an ack
    pim_in_ack_i = 1;
    #2 rst_ni = 0;
    @(posedge clk_i); #1;
    pim_in_ack_i = 0;
    model_reset();
    check_model();
    chk_vec("arst_input", pim_input_o, '0);
    #2 rst_ni = 1;

    // randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      int c;
      c = ($urandom_range(0, 15) != 0) ? m_exp : int'($urandom_range(0, 31));
      cyc($urandom_range(0, 3) != 0, c, $urandom, $urandom_range(0, 3) == 0, $urandom_range(0, 199) == 0);
      if (m_seq && $urandom_range(0, 9) == 0) cyc(0, 0, 0, 0, 1);
    end

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule
